// File: rtl/accum_pkg.sv
// Shared types and constants for the frame accumulator.
// Combinational only; no storage or flow control.
// Not applicable: declarations only.
package accum_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    localparam int ACC_W = 8;
    localparam logic [ACC_W-1:0] SAT_VAL = 8'hFF;
endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder producing sum and carry-out.
// Purely combinational, zero cycles.
// No backpressure; the caller qualifies when the result is used.
module adder_8bit
    import accum_pkg::*;
(
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    input  logic             i_cin,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_cout
);
    always_comb begin
        logic c;
        c      = i_cin;
        o_sum  = '0;
        for (int i = 0; i < ACC_W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ c;
            c        = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
        end
        o_cout = c;
    end
endmodule

// File: rtl/accum_frame_8bit.sv
// Frame accumulator: sums 8-bit samples until in_last, then holds sum/carry/count for the consumer.
// Result valid one cycle after the last sample; acc visible one cycle after each accept.
// Input stalls (in_ready=0) while a result waits; ACCUM_SATURATE_EN clamps acc at 8'hFF on carry.
module accum_frame_8bit
    import accum_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ACC_W-1:0]  in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic [CNT_W-1:0]  out_count
);
    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [ACC_W-1:0]   w_sum;
    logic               w_cout;
    logic [ACC_W-1:0]   w_next_acc;
    logic               w_accept;

    adder_8bit u_adder (
        .i_a    (r_acc),
        .i_b    (in_data),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // clear blocks the handshake even though in_ready is still high this cycle
    assign w_accept = in_valid & r_in_ready & ~clear;

`ifdef ACCUM_SATURATE_EN
    assign w_next_acc = w_cout ? SAT_VAL : w_sum;
`else
    assign w_next_acc = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_next_acc;
                        r_ovf <= r_ovf | w_cout;
                        r_cnt <= (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
                        if (in_last) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state     <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_cnt       <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_sum      = r_acc;
    assign out_overflow = r_ovf;
    assign out_count    = r_cnt;
endmodule

// File: tb/tb_accum_frame_8bit.sv
// Bench for accum_frame_8bit: directed frames plus random frames against a frame-total reference model.
module tb_accum_frame_8bit;
    localparam int TB_CNT_W = 2;
    localparam int CMAX     = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                n_rst;
    logic                clear;
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_last;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_sum;
    logic                out_overflow;
    logic [TB_CNT_W-1:0] out_count;

    int n_checks = 0;
    int n_errors = 0;
    int frame_q[$];

    accum_frame_8bit #(.CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected visible sum for a frame whose true (unbounded) total is t
    function automatic int exp_sum(input int t);
`ifdef ACCUM_SATURATE_EN
        return (t > 255) ? 255 : t;
`else
        return t % 256;
`endif
    endfunction

    function automatic int exp_cnt(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rdy"}, int'(in_ready), 1);
        check({tag, "_vld"}, int'(out_valid), 0);
        check({tag, "_sum"}, int'(out_sum), 0);
        check({tag, "_ovf"}, int'(out_overflow), 0);
        check({tag, "_cnt"}, int'(out_count), 0);
    endtask

    task automatic run_frame(input int gap_max, input int hold_cycles);
        int total;
        int n;
        total = 0;
        n     = frame_q.size();
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
                tick;
                check("gap_vld", int'(out_valid), 0);
                check("gap_cnt", int'(out_count), exp_cnt(i));
            end
            check("pre_rdy", int'(in_ready), 1);
            in_valid = 1'b1;
            in_data  = 8'(frame_q[i]);
            in_last  = (i == n - 1);
            tick;
            total += frame_q[i];
            check("acc_sum", int'(out_sum), exp_sum(total));
            check("acc_ovf", int'(out_overflow), (total > 255) ? 1 : 0);
            check("acc_cnt", int'(out_count), exp_cnt(i + 1));
            check("acc_vld", int'(out_valid), (i == n - 1) ? 1 : 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (hold_cycles) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick;
            check("hold_vld", int'(out_valid), 1);
            check("hold_rdy", int'(in_ready), 0);
            check("hold_sum", int'(out_sum), exp_sum(total));
            check("hold_cnt", int'(out_count), exp_cnt(n));
        end
        // Sample offered during the release cycle must be refused
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'($urandom_range(1, 255));
        in_last   = 1'b1;
        tick;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        check_idle("rel");
    endtask

    initial begin
        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'd55;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick;
        tick;
        check_idle("rst");
        n_rst    = 1'b1;
        in_valid = 1'b0;
        tick;
        check_idle("post_rst");

        frame_q = '{10, 20, 30};
        run_frame(0, 0);
        frame_q = '{200, 100};
        run_frame(0, 1);
        frame_q = '{7};
        run_frame(0, 5);
        frame_q = '{1, 1, 1, 1, 1};
        run_frame(1, 2);
        frame_q = '{255, 0, 1, 0};
        run_frame(0, 0);

        // Abort mid-frame; the sample presented alongside clear is dropped
        in_valid = 1'b1; in_data = 8'd5; tick;
        in_data  = 8'd6; tick;
        clear    = 1'b1; in_data = 8'd9; tick;
        clear    = 1'b0; in_valid = 1'b0;
        check_idle("clr_mid");
        frame_q = '{3};
        run_frame(0, 0);

        // Abort while a result is waiting
        in_valid = 1'b1; in_data = 8'd8; in_last = 1'b1; tick;
        check("done_vld", int'(out_valid), 1);
        in_valid = 1'b0; in_last = 1'b0; clear = 1'b1; tick;
        clear = 1'b0;
        check_idle("clr_done");

        // Reset mid-frame
        in_valid = 1'b1; in_data = 8'd100; tick;
        in_data  = 8'd200; tick;
        n_rst    = 1'b0; tick;
        n_rst    = 1'b1; in_valid = 1'b0;
        check_idle("rst_mid");

        for (int f = 0; f < 25; f++) begin
            int len;
            len = $urandom_range(1, 6);
            frame_q.delete();
            for (int k = 0; k < len; k++) frame_q.push_back($urandom_range(0, 255));
            run_frame(2, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/accum_frame_8bit.md
Name: accum_frame_8bit

Overview:
- Frame accumulator: accepts a stream of 8-bit unsigned samples over a valid/ready handshake and sums each frame (terminated by in_last).
- Presents the sum, a sticky carry-out flag and a sample count on a valid/ready output port.
- Sits directly upstream and downstream of the team's 8-bit ripple-carry adder:
  - drives its a/b/carry_in;
  - registers its sum/overflow.

Parameters:
- CNT_W, 4: width of the per-frame sample counter. Counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  synchronous active-low reset.
- clear  input  1  synchronous frame abort. Priority below n_rst, above all else.
- in_valid  input  1  sample present.
- in_data  input  8  unsigned sample.
- in_last  input  1  final sample of frame. Qualified by in_valid.
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  frame result held.
- out_ready  input  1  consumer accepts result.
- out_sum  output  8  frame sum.
- out_overflow  output  1  sticky: at least one adder carry-out occurred in the frame.
- out_count  output  CNT_W  number of samples accepted in the frame (saturating).

Behaviour:
- Clocking and reset: one clock, clk. Reset n_rst is synchronous, active-low.
- Reset values: state=IDLE, acc=0, ovf=0, cnt=0, in_ready=1, out_valid=0, out_sum=0, out_overflow=0, out_count=0.
- Accept rule: a sample is accepted on a rising edge where in_valid && in_ready.
- Datapath:
  - Adder inputs are a=acc, b=in_data, carry_in=0.
  - On accept: acc <= adder sum; ovf <= ovf | adder carry-out; cnt <= cnt+1 (held at max once reached).
  - Arithmetic is modulo 256.
- Latency: updated acc visible one cycle after accept.
- out_valid rises the cycle after the last sample is accepted.
- FSM states IDLE, ACCUM, DONE:
  - IDLE: in_ready=1, out_valid=0. Accept without last -> ACCUM. Accept with last -> DONE (single-sample frame).
  - ACCUM: in_ready=1, out_valid=0. Accept with last -> DONE. Otherwise stay.
  - DONE: in_ready=0, out_valid=1. out_sum/out_overflow/out_count stable. On out_ready=1: -> IDLE, acc/ovf/cnt <= 0.
  - One-cycle bubble between frames is required: no accept in the DONE->IDLE transition cycle.
- out_sum, out_overflow and out_count mirror acc, ovf and cnt in all states. Consumers sample them only while out_valid=1.
- clear:
  - Forces IDLE and acc/ovf/cnt=0 next edge in any state, including DONE with out_valid=1 (result dropped).
  - A sample offered in the same cycle as clear is not accepted, even though in_ready=1 that cycle.
- in_valid may drop mid-frame: the block stays in ACCUM indefinitely.
- in_last with in_valid=0 is ignored.
- n_rst low mid-frame: identical to reset values above.

Optional Feature:
- Macro ACCUM_SATURATE_EN.
- Defined: on any accept where the adder carry-out=1, acc <= 8'hFF instead of the wrapped sum. ovf sets as normal. Further accepts keep acc at 8'hFF (including FF+0).
- Undefined: modulo-256 wrap as specified above.

Decomposition:
- Package accum_pkg:
  - typedef enum logic [1:0] state_t {IDLE, ACCUM, DONE};
  - localparam ACC_W=8;
  - localparam SAT_VAL=8'hFF.
- Sub-module: adder_8bit, one instance, combinational sum/carry for the datapath.
- FSM, registers, counter and saturation mux live in accum_frame_8bit.

Test Plan:
- Reset: hold n_rst=0 for 2 edges with in_valid=1 -> in_ready=1, out_valid=0, all outputs 0, no sample accepted.
- Basic frame: samples 10, 20, 30 (last on 30), out_ready=1 -> out_valid one cycle after the 30 accept; out_sum=60, out_overflow=0, out_count=3; next cycle IDLE.
- Wrap: samples 200, 100 (last) -> out_sum=44, out_overflow=1, out_count=2.
  - With ACCUM_SATURATE_EN: out_sum=255, out_overflow=1.
- Backpressure: single sample 7 with last, out_ready=0 for 5 cycles -> out_valid stays 1, in_ready=0, out_sum=7 stable. A new in_valid sample is not accepted until after out_ready.
- Clear mid-frame: samples 5, 6, then clear=1 with in_valid=1, in_data=9 -> next cycle acc=0, state IDLE; the 9 is not accepted. Following frame 3 (last) -> out_sum=3, out_count=1.
- Count saturation: CNT_W=2, frame of 5 samples of 1 -> out_count=3, out_sum=5.
